// File: rtl/div_sched_pkg.sv
// Shared types and the round-robin pick used by the divider scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int NREQ_DEF = 4;
    localparam int ID_W     = $clog2(NREQ_DEF);
    localparam int MAX_REQ  = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, scanning upward modulo n (n <= MAX_REQ).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [4:0]         ptr,
                                      input int                 n);
        pick_t p;
        int    c;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            c = (int'(ptr) + k) % n;
            if (k < n && !p.found && req[c[4:0]]) begin
                p.found = 1'b1;
                p.idx   = c[4:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/div_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick from a registered pointer that moves past each grant.
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic            found,
    output logic [IDW-1:0]  grant
);

    logic [IDW-1:0] ptr;
    pick_t          pick;
    logic           unused_pick_bits;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req), 5'(ptr), NREQ);
        found = pick.found;
        grant = pick.idx[IDW-1:0];
    end

    assign unused_pick_bits = ^pick.idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
        end
    end

endmodule

// File: rtl/div_rr_scheduler.sv
// Shares one divider among NREQ requesters; answers divide-by-zero locally and
// bounds the wait for done with a watchdog.
module div_rr_scheduler
    import div_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [IDW-1:0]  resp_id,
    output logic [W-1:0]    resp_quotient,
    output logic [W-1:0]    resp_remainder,
    output logic            resp_div0,
    output logic            resp_timeout,
    output logic            div_start,
    output logic [W-1:0]    div_dividend,
    output logic [W-1:0]    div_divisor,
    input  logic [W-1:0]    div_quotient,
    input  logic [W-1:0]    div_remainder,
    input  logic            div_done
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t         state, state_nxt;
    logic           found, advance;
    logic [IDW-1:0] gnt;
    logic [W-1:0]   dvd_sel, dvs_sel;
    logic           dvs_zero, done_q, done_edge, wd_expired;
    logic [WD_W-1:0] wd_cnt;

    assign dvd_sel    = req_dividend[int'(gnt)*W +: W];
    assign dvs_sel    = req_divisor[int'(gnt)*W +: W];
    assign dvs_zero   = (dvs_sel == '0);
    assign done_edge  = div_done & ~done_q;
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (advance),
        .found   (found),
        .grant   (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshakes: a request transfers when req_valid[i] & req_ready[i] at a clock edge;
    // a response transfers when resp_valid & resp_ready, and its fields hold until then.
    always_comb begin
        state_nxt  = state;
        advance    = 1'b0;
        req_ready  = '0;
        div_start  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    advance        = 1'b1;
                    // rst_n gating keeps req_ready low while reset is held
                    req_ready[gnt] = rst_n;
                    state_nxt      = dvs_zero ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_edge || wd_expired) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q         <= 1'b0;
            wd_cnt         <= '0;
            resp_id        <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_div0      <= 1'b0;
            resp_timeout   <= 1'b0;
            div_dividend   <= '0;
            div_divisor    <= '0;
        end else begin
            done_q <= div_done;
            case (state)
                IDLE: begin
                    if (found) begin
                        resp_id        <= gnt;
                        div_dividend   <= dvd_sel;
                        div_divisor    <= dvs_sel;
                        resp_div0      <= dvs_zero;
                        resp_timeout   <= 1'b0;
                        resp_quotient  <= dvs_zero ? {W{1'b1}} : '0;
                        resp_remainder <= dvs_zero ? dvd_sel : '0;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    // A completion on the last watchdog cycle still wins over the timeout
                    if (done_edge) begin
                        resp_quotient  <= div_quotient;
                        resp_remainder <= div_remainder;
                    end else if (wd_expired) begin
                        resp_quotient  <= '0;
                        resp_remainder <= '0;
                        resp_timeout   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Directed bench for div_rr_scheduler with a behavioural divider and a response scoreboard.
module tb_div_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_dividend, req_divisor;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_quotient, resp_remainder;
    logic        resp_div0, resp_timeout;
    logic        div_start;
    logic [15:0] div_dividend, div_divisor, div_quotient, div_remainder;
    logic        div_done;

    div_rr_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .resp_div0(resp_div0), .resp_timeout(resp_timeout),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int pcyc = 0;
    initial forever begin
        @(posedge clk);
        pcyc++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard state ----------------
    logic [35:0] exp_q[$];
    int          grant_log[$];
    int          resp_count = 0, start_count = 0;
    int          grant_pc = 0, start_pc = 0, resp_pc = 0, done_pc = 0;
    logic [3:0]  last_grant = '0;
    logic        prev_rv = 1'b0, prev_start = 1'b0;
    int          pend[4];
    bit          stuck = 1'b0;

    task automatic push_exp(input logic [1:0] id, input logic [15:0] q, input logic [15:0] r,
                            input logic d0, input logic to);
        exp_q.push_back({id, q, r, d0, to});
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            last_grant = '0;
            prev_rv    = 1'b0;
            prev_start = 1'b0;
        end else begin
            last_grant = req_ready;
            if (req_ready != '0) begin
                check("ready_onehot", {63'd0, $onehot(req_ready)}, 64'd1);
                for (int i = 0; i < 4; i++) if (req_ready[i]) grant_log.push_back(i);
                grant_pc = pcyc;
            end
            if (div_start) begin
                check("start_single_cycle", {63'd0, prev_start}, 64'd0);
                start_count++;
                start_pc = pcyc;
            end
            prev_start = div_start;
            if (resp_valid && !prev_rv) resp_pc = pcyc;
            prev_rv = resp_valid;
            if (resp_valid && resp_ready) begin
                check("resp_expected_pending", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0)
                    check("resp", {resp_id, resp_quotient, resp_remainder, resp_div0, resp_timeout},
                          exp_q.pop_front());
                resp_count++;
            end
        end
    end

    // ---------------- divider model ----------------
    // Holds done as a level until the next op has been in WAIT for a cycle, so a
    // stale level overlaps the new op's first WAIT edge.
    initial begin
        logic [15:0] a, b;
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        forever begin
            @(negedge clk);
            if (div_start === 1'b1) begin
                a = div_dividend; b = div_divisor;
                repeat (2) @(negedge clk);
                div_done = 1'b0;
                if (!stuck) begin
                    repeat (3) @(negedge clk);
                    div_quotient  = a / b;
                    div_remainder = a % b;
                    div_done      = 1'b1;
                    done_pc       = pcyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (last_grant[i] && pend[i] > 0) pend[i]--;
            req_valid[i] = (pend[i] != 0);
        end
    end

    task automatic at_slot();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [15:0] dvd, input logic [15:0] dvs, input int n);
        req_dividend[i*16 +: 16] = dvd;
        req_divisor[i*16 +: 16]  = dvs;
        pend[i] += n;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_resps(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (resp_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_resp_count"}, 64'(resp_count), 64'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) pend[i] = 0;
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, resp_div0, resp_timeout, div_start},
              64'd0);
        check("reset_div_operands", {div_dividend, div_divisor}, 64'd0);
        rst_n = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int sc, rc, k;
        req_dividend = '0; req_divisor = '0;
        do_reset();

        // 1: single request 100/7
        sc = start_count;
        push_exp(2'd0, 16'd14, 16'd2, 1'b0, 1'b0);
        at_slot(); set_req(0, 16'd100, 16'd7, 1);
        wait_resps(1, 60, "t1");
        check("t1_start_pulses", 64'(start_count - sc), 64'd1);
        check("t1_grant_to_start", 64'(start_pc - grant_pc), 64'd1);
        check("t1_done_to_resp", 64'(resp_pc - done_pc), 64'd1);

        // 2: all four continuously valid after reset, requester 0 twice
        do_reset();
        grant_log.delete();
        rc = resp_count;
        push_exp(2'd0, 16'd257, 16'd0, 1'b0, 1'b0);
        push_exp(2'd1, 16'd10, 16'd0, 1'b0, 1'b0);
        push_exp(2'd2, 16'd30, 16'd10, 1'b0, 1'b0);
        push_exp(2'd3, 16'd0, 16'd7, 1'b0, 1'b0);
        push_exp(2'd0, 16'd257, 16'd0, 1'b0, 1'b0);
        at_slot();
        set_req(0, 16'd65535, 16'd255, 2);
        set_req(1, 16'd50, 16'd5, 1);
        set_req(2, 16'd1000, 16'd33, 1);
        set_req(3, 16'd7, 16'd9, 1);
        wait_resps(rc + 5, 200, "t2");
        check("t2_grant_count", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("t2_grant_order", 64'(grant_log[i]), 64'(i % 4));

        // 3: divide by zero on requester 2
        sc = start_count; rc = resp_count;
        push_exp(2'd2, 16'hFFFF, 16'd1234, 1'b1, 1'b0);
        at_slot(); set_req(2, 16'd1234, 16'd0, 1);
        wait_resps(rc + 1, 30, "t3");
        check("t3_no_start", 64'(start_count - sc), 64'd0);
        check("t3_grant_to_resp", 64'(resp_pc - grant_pc), 64'd1);

        // 4: backpressure; pointer sits at 3 so requester 3 wins over 1
        rc = resp_count;
        @(posedge clk); #1 resp_ready = 1'b0;
        push_exp(2'd3, 16'd4, 16'd0, 1'b0, 1'b0);
        push_exp(2'd1, 16'd3, 16'd2, 1'b0, 1'b0);
        at_slot();
        set_req(1, 16'd20, 16'd6, 1);
        set_req(3, 16'd8, 16'd2, 1);
        k = 0;
        while (!resp_valid && k < 60) begin @(negedge clk); k++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold",
                  {resp_valid, resp_id, resp_quotient, resp_remainder, resp_div0, resp_timeout, req_ready, div_start},
                  {22'd0, 1'b1, 2'd3, 16'd4, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0});
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        wait_resps(rc + 2, 80, "t4");

        // 5: stuck divider times out, then a normal op
        stuck = 1'b1; rc = resp_count;
        push_exp(2'd0, 16'd0, 16'd0, 1'b0, 1'b1);
        at_slot(); set_req(0, 16'd5, 16'd1, 1);
        wait_resps(rc + 1, 200, "t5_timeout");
        check("t5_start_to_resp", 64'(resp_pc - start_pc), 64'd65);
        stuck = 1'b0;
        push_exp(2'd1, 16'd7, 16'd3, 1'b0, 1'b0);
        at_slot(); set_req(1, 16'd45, 16'd6, 1);
        wait_resps(rc + 2, 60, "t5_after");

        // 6: reset while waiting on the divider
        stuck = 1'b1; sc = start_count;
        at_slot(); set_req(2, 16'd11, 16'd5, 1);
        k = 0;
        while (start_count == sc && k < 30) begin @(negedge clk); k++; end
        check("t6_started", 64'(start_count - sc), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        for (int i = 0; i < 4; i++) pend[i] = 0;
        req_valid = '0;
        #1;
        check("t6_reset_outputs",
              {req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, resp_div0, resp_timeout, div_start},
              64'd0);
        check("t6_reset_operands", {div_dividend, div_divisor}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rc = resp_count;
        repeat (20) @(negedge clk);
        check("t6_no_resp_after_reset", 64'(resp_count), 64'(rc));
        stuck = 1'b0;
        push_exp(2'd0, 16'd3, 16'd0, 1'b0, 1'b0);
        at_slot(); set_req(0, 16'd9, 16'd3, 1);
        wait_resps(rc + 1, 60, "t6_after");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
